// File: rtl/scr1_ntt_sched_pkg.sv
// Shared types and sizing helpers for the NTT memory scheduler.
package scr1_ntt_sched_pkg;

    // Number of 32-bit words carried by one memory/NTT beat.
    localparam int unsigned SCR1_NTT_LANE = 8;

    typedef logic [SCR1_NTT_LANE*32-1:0] type_vector;
    typedef type_vector                  lane_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StStore,
        StDone
    } ntt_sched_state_e;

    // Beats per transform.
    function automatic int unsigned ntt_beats(input int unsigned n, input int unsigned lane);
        return n / lane;
    endfunction

    // One spare bit so a counter can hold the full beat count.
    function automatic int unsigned ntt_cnt_width(input int unsigned beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/scr1_ntt_mem_sched.sv
// Streams one NTT job: memory port B -> NTT core (LOAD), then NTT results -> memory (STORE).
// Owns port B while busy; result writes preempt reads when the NTT answers early.
module scr1_ntt_mem_sched
    import scr1_ntt_sched_pkg::*;
#(
    parameter int unsigned LANE = SCR1_NTT_LANE,
    parameter int unsigned N    = 512,
    parameter int unsigned AW   = 14,
    parameter int unsigned WDOG = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic [AW-1:0] cfg_src,
    input  logic [AW-1:0] cfg_dst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic          mem_w_is_vec,
    output logic [3:0]    mem_webb,
    output logic [AW-1:0] mem_addr,
    output type_vector    mem_wdata,
    input  type_vector    mem_rdata,
    output logic          ntt_valid_in,
    output lane_t         ntt_lane_in,
    input  logic          ntt_valid_out,
    input  lane_t         ntt_lane_out
);

    localparam int unsigned BEATS = ntt_beats(N, LANE);
    localparam int unsigned CW    = ntt_cnt_width(BEATS);
    localparam int unsigned LSH   = $clog2(LANE);
    localparam int unsigned WW    = $clog2(WDOG + 1);

    localparam logic [CW-1:0] BeatsC = CW'(BEATS);
    localparam logic [CW-1:0] LastC  = CW'(BEATS - 1);
    localparam logic [WW-1:0] WdogC  = WW'(WDOG - 1);

    ntt_sched_state_e state_q, state_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             ren_q;

    logic             wr_fire;
    logic             rd_fire;
    logic [AW-1:0]    rd_off;
    logic [AW-1:0]    wr_off;

    // A result beat is written whenever the job can still take one; it wins the port over reads.
    assign wr_fire = ntt_valid_out && (state_q inside {StLoad, StWait, StStore})
                     && (wr_cnt_q < BeatsC);
    assign rd_fire = (state_q == StLoad) && !wr_fire;

    // Base + beat*LANE; wraps modulo 2^AW.
    assign rd_off = AW'(rd_cnt_q) << LSH;
    assign wr_off = AW'(wr_cnt_q) << LSH;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            ren_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            ren_q    <= rd_fire;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        wdog_d   = wdog_q;
        err_d    = err_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    src_d    = cfg_src;
                    dst_d    = cfg_dst;
                    err_d    = 1'b0;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                wdog_d = '0;
                if (rd_fire) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (rd_cnt_q == LastC) begin
                        // Results that arrived early mean the NTT is already draining.
                        state_d = (wr_cnt_q != '0) ? StStore : StWait;
                    end
                end
            end
            StWait: begin
                if (wr_fire) begin
                    state_d = (wr_cnt_q == LastC) ? StDone : StStore;
                end else if (wdog_q == WdogC) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            StStore: begin
                if (wr_fire && (wr_cnt_q == LastC)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Port B, NTT and status outputs.
    always_comb begin
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        err          = err_q;
        mem_ren      = rd_fire;
        mem_wen      = wr_fire;
        mem_w_is_vec = wr_fire;
        mem_webb     = 4'hF;
        mem_addr     = '0;
        if (wr_fire) begin
            mem_addr = dst_q + wr_off;
        end else if (rd_fire) begin
            mem_addr = src_q + rd_off;
        end
        mem_wdata    = wr_fire ? ntt_lane_out : '0;
        ntt_valid_in = ren_q;
        ntt_lane_in  = ren_q ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_scr1_ntt_mem_sched.sv
// Scoreboard bench for scr1_ntt_mem_sched with a memory model and a latency-programmable NTT model.
module tb_scr1_ntt_mem_sched;
    import scr1_ntt_sched_pkg::*;

    localparam int unsigned LANE  = SCR1_NTT_LANE;
    localparam int unsigned N     = 512;
    localparam int unsigned AW    = 14;
    localparam int unsigned WDOG  = 4096;
    localparam int unsigned BEATS = N / LANE;
    localparam int          AMASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW-1:0] cfg_src;
    logic [AW-1:0] cfg_dst;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_ren;
    logic          mem_wen;
    logic          mem_w_is_vec;
    logic [3:0]    mem_webb;
    logic [AW-1:0] mem_addr;
    type_vector    mem_wdata;
    type_vector    mem_rdata;
    logic          ntt_valid_in;
    lane_t         ntt_lane_in;
    logic          ntt_valid_out;
    lane_t         ntt_lane_out;

    scr1_ntt_mem_sched #(
        .LANE (LANE),
        .N    (N),
        .AW   (AW),
        .WDOG (WDOG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_src       (cfg_src),
        .cfg_dst       (cfg_dst),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_w_is_vec  (mem_w_is_vec),
        .mem_webb      (mem_webb),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .ntt_valid_in  (ntt_valid_in),
        .ntt_lane_in   (ntt_lane_in),
        .ntt_valid_out (ntt_valid_out),
        .ntt_lane_out  (ntt_lane_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        type_vector data;
    } wr_t;

    typedef struct {
        int         due;
        type_vector data;
    } pipe_t;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         done_seen   = 0;
    int         wr_seen     = 0;
    bit         exp_err     = 1'b0;
    int         seed        = 0;
    int         ntt_lat     = 100;
    int         ntt_mode    = 0;    // 0 in-order, 1 random output gaps, 2 never answers
    type_vector ntt_key     = '0;

    int         exp_rd[$];
    type_vector exp_vin[$];
    wr_t        exp_wr[$];
    pipe_t      pipe[$];

    function automatic void chk(input bit ok, input string nm, input string act, input string req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %s, expected %s", nm, act, req);
        end
    endfunction

    // Memory contents are a fixed function of address and a per-job seed.
    function automatic type_vector mem_val(input int addr, input int s);
        type_vector v;
        for (int k = 0; k < LANE; k++) begin
            v[k*32 +: 32] = (32'(addr + k) * 32'h9E37_79B1) ^ 32'(s) ^ 32'(addr << 7);
        end
        return v;
    endfunction

    function automatic type_vector ntt_fn(input type_vector v, input type_vector key);
        return ~v ^ key;
    endfunction

    function automatic type_vector rand_vec();
        type_vector v;
        for (int k = 0; k < LANE; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Environment: memory read port and NTT core model.
    initial begin
        bit    s_ren;
        int    s_addr;
        pipe_t p;
        mem_rdata     = '0;
        ntt_valid_out = 1'b0;
        ntt_lane_out  = '0;
        forever begin
            @(negedge clk);
            s_ren  = mem_ren;
            s_addr = int'(mem_addr);
            if (!rst_n) begin
                pipe.delete();
            end else if (ntt_valid_in && ntt_mode != 2) begin
                p.due  = cyc + ntt_lat;
                p.data = ntt_fn(ntt_lane_in, ntt_key);
                pipe.push_back(p);
            end
            @(posedge clk);
            cyc++;
            #1;
            mem_rdata     = s_ren ? mem_val(s_addr, seed) : rand_vec();
            ntt_valid_out = 1'b0;
            ntt_lane_out  = rand_vec();
            if (rst_n && pipe.size() > 0 && pipe[0].due <= cyc
                && !(ntt_mode == 1 && $urandom_range(0, 3) == 0)) begin
                p             = pipe.pop_front();
                ntt_valid_out = 1'b1;
                ntt_lane_out  = p.data;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read, NTT beat, write or done.
    initial begin
        bit  busy_prev = 1'b0;
        bit  done_prev = 1'b0;
        bit  err_prev  = 1'b0;
        bit  vin_pend  = 1'b0;
        int  last_vin  = 0;
        int  start_cyc = 0;
        int  ea;
        type_vector ev;
        wr_t ew;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk({busy, done, err, mem_ren, mem_wen, ntt_valid_in, mem_w_is_vec} == '0
                    && mem_addr == '0 && ntt_lane_in == '0 && mem_wdata == '0,
                    "reset_outputs",
                    $sformatf("%b addr=%h", {busy, done, err, mem_ren, mem_wen, ntt_valid_in,
                              mem_w_is_vec}, mem_addr), "0000000 addr=0000");
                exp_rd.delete();
                exp_vin.delete();
                exp_wr.delete();
                busy_prev = 1'b0;
                done_prev = 1'b0;
                err_prev  = 1'b0;
                vin_pend  = 1'b0;
                continue;
            end
            if (cfg_start && !busy) begin
                start_cyc = cyc;
                vin_pend  = 1'b1;
            end
            if (mem_ren || mem_wen) begin
                chk(!(mem_ren && mem_wen), "port_exclusive",
                    $sformatf("ren=%b wen=%b", mem_ren, mem_wen), "not both");
            end
            if (mem_ren) begin
                chk(exp_rd.size() > 0, "rd_unexpected", $sformatf("addr=%h", mem_addr), "no read");
                if (exp_rd.size() > 0) begin
                    ea = exp_rd.pop_front();
                    chk(int'(mem_addr) == ea, "rd_addr", $sformatf("%h", mem_addr),
                        $sformatf("%h", ea));
                end
            end
            if (ntt_valid_in) begin
                if (vin_pend) begin
                    chk(cyc - start_cyc == 2, "load_latency", $sformatf("%0d", cyc - start_cyc),
                        "2");
                    vin_pend = 1'b0;
                end
                last_vin = cyc;
                chk(exp_vin.size() > 0, "vin_unexpected", "beat", "no beat");
                if (exp_vin.size() > 0) begin
                    ev = exp_vin.pop_front();
                    chk(ntt_lane_in == ev, "ntt_lane_in", $sformatf("%h", ntt_lane_in),
                        $sformatf("%h", ev));
                end
            end
            if (mem_wen) begin
                wr_seen++;
                chk(mem_w_is_vec && mem_webb == 4'hF, "wr_ctrl",
                    $sformatf("vec=%b webb=%h", mem_w_is_vec, mem_webb), "vec=1 webb=f");
                chk(exp_wr.size() > 0, "wr_unexpected", $sformatf("addr=%h", mem_addr),
                    "no write");
                if (exp_wr.size() > 0) begin
                    ew = exp_wr.pop_front();
                    chk(int'(mem_addr) == ew.addr && mem_wdata == ew.data, "wr_beat",
                        $sformatf("%h:%h", mem_addr, mem_wdata),
                        $sformatf("%h:%h", ew.addr, ew.data));
                end
            end
            if (!busy) begin
                chk(!mem_ren && !mem_wen && !ntt_valid_in, "idle_quiet",
                    $sformatf("%b%b%b", mem_ren, mem_wen, ntt_valid_in), "000");
            end
            if (done_prev) begin
                chk(!busy, "busy_after_done", $sformatf("%b", busy), "0");
            end
            if (done) begin
                done_seen++;
                chk(!done_prev, "done_single", "done on two cycles", "one cycle");
                chk(exp_rd.size() == 0 && exp_vin.size() == 0 && exp_wr.size() == 0,
                    "job_complete",
                    $sformatf("left rd=%0d vin=%0d wr=%0d", exp_rd.size(), exp_vin.size(),
                              exp_wr.size()), "left rd=0 vin=0 wr=0");
                chk(err == exp_err, "err_at_done", $sformatf("%b", err),
                    $sformatf("%b", exp_err));
            end
            if (err && !err_prev) begin
                chk(cyc - last_vin == WDOG, "wdog_timing", $sformatf("%0d", cyc - last_vin),
                    $sformatf("%0d", WDOG));
            end
            if (busy && !busy_prev) begin
                chk(!err, "err_cleared_on_start", $sformatf("%b", err), "0");
            end
            if (err_prev && !busy) begin
                chk(err, "err_sticky", $sformatf("%b", err), "1");
            end
            busy_prev = busy;
            done_prev = done;
            err_prev  = err;
        end
    end

    task automatic run_job(input int src, input int dst, input int lat, input int mode,
                           input bit mid_start, input int abort_after);
        int a;
        int d0;
        int w0;
        wr_t w;
        seed     = $urandom;
        ntt_key  = rand_vec();
        ntt_lat  = lat;
        ntt_mode = mode;
        exp_err  = (mode == 2);
        for (int i = 0; i < BEATS; i++) begin
            a = (src + LANE * i) & AMASK;
            exp_rd.push_back(a);
            exp_vin.push_back(mem_val(a, seed));
            if (mode != 2) begin
                w.addr = (dst + LANE * i) & AMASK;
                w.data = ntt_fn(mem_val(a, seed), ntt_key);
                exp_wr.push_back(w);
            end
        end
        d0 = done_seen;
        w0 = wr_seen;
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        cfg_src   = AW'(src);
        cfg_dst   = AW'(dst);
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        if (mid_start) begin
            repeat (30) @(posedge clk);
            #1;
            cfg_start = 1'b1;
            cfg_src   = AW'(src + 24);
            cfg_dst   = AW'(dst + 40);
            @(posedge clk);
            #1;
            cfg_start = 1'b0;
        end
        if (abort_after > 0) begin
            for (int t = 0; t < 2000; t++) begin
                @(posedge clk);
                if (wr_seen >= w0 + abort_after) break;
            end
            #2;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk(!busy && wr_seen == w0 + abort_after, "reset_mid_store",
                $sformatf("busy=%b writes=%0d", busy, wr_seen - w0),
                $sformatf("busy=0 writes=%0d", abort_after));
        end else begin
            for (int t = 0; t < WDOG + 3000 && done_seen == d0; t++) @(posedge clk);
            chk(done_seen == d0 + 1, "job_done", $sformatf("%0d done", done_seen - d0), "1 done");
            if (done_seen == d0) begin
                exp_rd.delete();
                exp_vin.delete();
                exp_wr.delete();
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_src   = '0;
        cfg_dst   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk({busy, done, err} == 3'b000, "post_reset_idle", $sformatf("%b", {busy, done, err}),
            "000");

        run_job(0, 'h400, 100, 0, 1'b0, 0);
        run_job('h800, 'hC00, 10, 0, 1'b0, 0);
        run_job('h900, 'hD00, 1, 0, 1'b0, 0);
        run_job('h100, 'h2000, 0, 2, 1'b0, 0);
        repeat (5) @(posedge clk);
        run_job((1 << AW) - 16, 'h3000, 50, 0, 1'b1, 0);
        run_job(0, 'h1000, 100, 0, 1'b0, 20);
        run_job('h40, 'h1000, 20, 0, 1'b0, 0);
        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(0, AMASK)) & ~7, int'($urandom_range(0, AMASK)) & ~7,
                    int'($urandom_range(1, 150)), int'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
